// File: rtl/nd120_cyc_pkg.sv
// nd120_cyc_pkg
// Shared definitions for the ND-120/CX cycle timing logic.
// - CTYPE encodings.
// - The cycle-generator state encoding.
// - The default timeout length.
package nd120_cyc_pkg;

  typedef enum logic [2:0] {
    CT_CACHE_RD  = 3'd0,
    CT_MEM_RD    = 3'd1,
    CT_MEM_WR    = 3'd2,
    CT_IO_SLOW   = 3'd3,
    CT_CS_ACCESS = 3'd4,
    CT_UART      = 3'd5
  } ctype_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned TMO_CYCLES_DEF = 255;

  // Codes 6 and 7 have no cycle of their own and behave as a memory read.
  function automatic ctype_e to_ctype(input logic [2:0] code);
    ctype_e t;
    if (code > 3'd5) t = CT_MEM_RD;
    else             t = ctype_e'(code);
    return t;
  endfunction

endpackage

// File: rtl/cyc_dncnt.sv
// cyc_dncnt
// Loadable down-counter that saturates at zero, with a zero flag.
// Ports:
//   ck       clock
//   rst      synchronous reset, active-high (count <- 0)
//   clr      synchronous clear (count <- 0), beats load and dec
//   load     load load_val, beats dec
//   load_val value to load
//   dec      decrement by one, holds at zero
//   cnt      current count
//   zero     high when cnt == 0
module cyc_dncnt #(
  parameter int W = 2
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge ck) begin
    if (rst || clr)              cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cyc_wait_gen.sv
// cyc_wait_gen
// Cycle timing generator feeding the CYCFSM state counter. Latches the
// cycle type and wait parameters at START, then produces the delay/wait
// qualifiers until TERM_n ends the cycle or the timeout aborts it.
// Ports:
//   CK, RST            clock, synchronous active-high reset
//   START              begin a cycle (ignored while BUSY)
//   CTYPE/WSCNT/DLYSEL cycle type, wait states, setup delay (taken at START)
//   BUSRDY             bus ready, asynchronous, registered once here
//   TERM_n             cycle terminate from CYCFSM, active-low
//   DLY0_n, DLY1_n     low while delay count >= 1 / >= 2
//   CSDELAY0           first clock of a CS_ACCESS cycle
//   WAIT1              wait count non-zero
//   WAIT2              BUSY and registered BUSRDY low
//   SHORT_n, SLOW_n    cycle-class decodes, low for the whole cycle
//   BUSY               cycle in progress
//   TMO                one-clock pulse after a timeout abort
module cyc_wait_gen
  import nd120_cyc_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic [2:0] CTYPE,
  input  logic [2:0] WSCNT,
  input  logic [1:0] DLYSEL,
  input  logic       BUSRDY,
  input  logic       TERM_n,
  output logic       DLY0_n,
  output logic       DLY1_n,
  output logic       CSDELAY0,
  output logic       WAIT1,
  output logic       WAIT2,
  output logic       SHORT_n,
  output logic       SLOW_n,
  output logic       BUSY,
  output logic       TMO
);

  // tcnt equals this value during the TMO_CYCLES-th BUSY clock.
  localparam logic [7:0] TCNT_LAST = 8'(TMO_CYCLES - 1);

  state_e     state, state_nxt;
  ctype_e     ctype_q;
  logic       csd_q;
  logic       busrdy_q;
  logic       tmo_q;
  logic [7:0] tcnt;
  logic [1:0] dcnt;
  logic [2:0] wcnt;
  logic       dzero, wzero;
  logic       start_acc, term_hit, tmo_hit, cyc_end;

  // ---------------------------------------------------------------- state
  always_ff @(posedge CK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ----------------------------------------------------------- next state
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    term_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        start_acc = START;
        if (START) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        // TERM has priority over both the timeout and a late START.
        term_hit = !TERM_n;
        tmo_hit  = TERM_n && (tcnt == TCNT_LAST);
        if (term_hit || tmo_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cyc_end = term_hit || tmo_hit;

  // ------------------------------------------------ cycle context registers
  always_ff @(posedge CK) begin
    if (RST) begin
      ctype_q  <= CT_MEM_RD;
      csd_q    <= 1'b0;
      tcnt     <= '0;
      tmo_q    <= 1'b0;
      busrdy_q <= 1'b1;
    end else begin
      busrdy_q <= BUSRDY;
      tmo_q    <= tmo_hit;
      if (start_acc) begin
        ctype_q <= to_ctype(CTYPE);
        csd_q   <= (to_ctype(CTYPE) == CT_CS_ACCESS);
        tcnt    <= '0;
      end else if (cyc_end) begin
        csd_q <= 1'b0;
        tcnt  <= '0;
      end else if (state == ST_BUSY) begin
        csd_q <= 1'b0;
        tcnt  <= tcnt + 8'd1;
      end
    end
  end

  // Delay and wait counters: loaded at START, counted down through BUSY.
  cyc_dncnt #(.W(2)) u_dcnt (
    .ck       (CK),
    .rst      (RST),
    .clr      (cyc_end),
    .load     (start_acc),
    .load_val (DLYSEL),
    .dec      (state == ST_BUSY),
    .cnt      (dcnt),
    .zero     (dzero)
  );

  cyc_dncnt #(.W(3)) u_wcnt (
    .ck       (CK),
    .rst      (RST),
    .clr      (cyc_end),
    .load     (start_acc),
    .load_val (WSCNT),
    .dec      (state == ST_BUSY),
    .cnt      (wcnt),
    .zero     (wzero)
  );

  // --------------------------------------------------------------- outputs
  // Pure decodes of registers; counters are cleared on cycle exit, so the
  // count-based qualifiers are inactive in IDLE without extra gating.
  always_comb begin
    BUSY     = (state == ST_BUSY);
    DLY0_n   = dzero;
    DLY1_n   = !dcnt[1];
    CSDELAY0 = csd_q;
    WAIT1    = !wzero;
    WAIT2    = BUSY && !busrdy_q;
    SHORT_n  = !(BUSY && ctype_q == CT_CACHE_RD);
    SLOW_n   = !(BUSY && (ctype_q == CT_IO_SLOW || ctype_q == CT_UART));
    TMO      = tmo_q;
  end

endmodule

// File: tb/tb_cyc_wait_gen.sv
// tb_cyc_wait_gen
// Directed scenarios followed by randomized traffic. Every clock the DUT
// outputs are compared with a cycle-level model that tracks "which BUSY
// clock of which cycle are we in" and derives each qualifier arithmetically.
module tb_cyc_wait_gen;

  localparam int TMO = 255;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [2:0] CTYPE = 3'd0;
  logic [2:0] WSCNT = 3'd0;
  logic [1:0] DLYSEL = 2'd0;
  logic       BUSRDY = 1'b1;
  logic       TERM_n = 1'b1;
  logic       DLY0_n, DLY1_n, CSDELAY0, WAIT1, WAIT2, SHORT_n, SLOW_n, BUSY, TMO_o;

  cyc_wait_gen #(.TMO_CYCLES(TMO)) dut (
    .CK       (CK),
    .RST      (RST),
    .START    (START),
    .CTYPE    (CTYPE),
    .WSCNT    (WSCNT),
    .DLYSEL   (DLYSEL),
    .BUSRDY   (BUSRDY),
    .TERM_n   (TERM_n),
    .DLY0_n   (DLY0_n),
    .DLY1_n   (DLY1_n),
    .CSDELAY0 (CSDELAY0),
    .WAIT1    (WAIT1),
    .WAIT2    (WAIT2),
    .SHORT_n  (SHORT_n),
    .SLOW_n   (SLOW_n),
    .BUSY     (BUSY),
    .TMO      (TMO_o)
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  // Reference model: cycle in progress, index of the current BUSY clock
  // (1 = first), parameters taken at START, last sampled BUSRDY, TMO pulse.
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_ty   = 0;
  int m_dly  = 0;
  int m_ws   = 0;
  bit m_rdy  = 1'b1;
  bit m_tmo  = 1'b0;

  // Per-scenario observation counters.
  int n_w1, n_w2, n_d0, n_d1, n_csd, n_slow, n_tmo, n_busy;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {BUSY, DLY0_n, DLY1_n, CSDELAY0, WAIT1, WAIT2, SHORT_n, SLOW_n, TMO_o};
  endfunction

  function automatic logic [8:0] model_vec();
    logic [8:0] v;
    v[8] = m_busy;
    v[7] = !(m_busy && m_k <= m_dly);
    v[6] = !(m_busy && m_k <= m_dly - 1);
    v[5] = m_busy && m_k == 1 && m_ty == 4;
    v[4] = m_busy && m_k <= m_ws;
    v[3] = m_busy && !m_rdy;
    v[2] = !(m_busy && m_ty == 0);
    v[1] = !(m_busy && (m_ty == 3 || m_ty == 5));
    v[0] = m_tmo;
    return v;
  endfunction

  task automatic model_step();
    if (RST) begin
      m_busy = 1'b0; m_k = 0; m_tmo = 1'b0; m_rdy = 1'b1;
    end else begin
      m_tmo = 1'b0;
      if (m_busy) begin
        if (!TERM_n) m_busy = 1'b0;
        else if (m_k == TMO) begin m_busy = 1'b0; m_tmo = 1'b1; end
        else m_k++;
      end else if (START) begin
        m_busy = 1'b1; m_k = 1;
        m_ty = int'(CTYPE); m_dly = int'(DLYSEL); m_ws = int'(WSCNT);
      end
      m_rdy = BUSRDY;
    end
  endtask

  task automatic clear_counts();
    n_w1 = 0; n_w2 = 0; n_d0 = 0; n_d1 = 0;
    n_csd = 0; n_slow = 0; n_tmo = 0; n_busy = 0;
  endtask

  // One clock: edge, model update, then compare 1 ns later.
  task automatic tick(input string tag);
    @(posedge CK);
    model_step();
    #1;
    check(tag, dut_vec(), model_vec());
    if (WAIT1)    n_w1++;
    if (WAIT2)    n_w2++;
    if (!DLY0_n)  n_d0++;
    if (!DLY1_n)  n_d1++;
    if (CSDELAY0) n_csd++;
    if (!SLOW_n)  n_slow++;
    if (TMO_o)    n_tmo++;
    if (BUSY)     n_busy++;
  endtask

  // Start a cycle, run it for len BUSY clocks, terminate, one idle clock.
  task automatic run_cycle(input string tag, input logic [2:0] ct,
                           input logic [2:0] ws, input logic [1:0] dl, input int len);
    clear_counts();
    CTYPE = ct; WSCNT = ws; DLYSEL = dl; START = 1'b1;
    tick(tag);
    START = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (i == len) TERM_n = 1'b0;
      tick(tag);
    end
    TERM_n = 1'b1;
    tick(tag);
  endtask

  initial begin
    // Reset with START held high.
    RST = 1'b1; START = 1'b1; CTYPE = 3'd0;
    tick("reset");
    tick("reset");
    check("reset_vals", dut_vec(), 9'b0_1_1_0_0_0_1_1_0);

    // Release reset with START still high: CACHE_RD starts on the next edge.
    RST = 1'b0;
    tick("cache_start");
    check("cache_busy_short", {7'd0, BUSY, SHORT_n}, 9'b0_0000_0010);
    START = 1'b0;
    tick("cache");
    TERM_n = 1'b0;
    tick("cache_term");
    TERM_n = 1'b1;
    tick("idle");

    // MEM_RD, WSCNT=3, DLYSEL=2, TERM at the 6th BUSY clock.
    run_cycle("memrd", 3'd1, 3'd3, 2'd2, 6);
    check("memrd_wait1_clks", 9'(n_w1), 9'd3);
    check("memrd_dly0_clks",  9'(n_d0), 9'd2);
    check("memrd_dly1_clks",  9'(n_d1), 9'd1);
    check("memrd_busy_clks",  9'(n_busy), 9'd6);

    // CS_ACCESS: CSDELAY0 for exactly one clock.
    run_cycle("cs", 3'd4, 3'd0, 2'd0, 5);
    check("cs_csd_clks", 9'(n_csd), 9'd1);
    check("cs_wait1_clks", 9'(n_w1), 9'd0);

    // IO_SLOW and UART: SLOW_n low for the whole cycle.
    run_cycle("ioslow", 3'd3, 3'd1, 2'd1, 7);
    check("ioslow_slow_clks", 9'(n_slow), 9'd7);
    run_cycle("uart", 3'd5, 3'd7, 2'd3, 4);
    check("uart_slow_clks", 9'(n_slow), 9'd4);

    // BUSRDY low for four samples, second START while BUSY ignored.
    clear_counts();
    CTYPE = 3'd2; WSCNT = 3'd2; DLYSEL = 2'd0; BUSRDY = 1'b0; START = 1'b1;
    tick("rdy_start");
    CTYPE = 3'd0; WSCNT = 3'd7;            // START stays high while BUSY
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) BUSRDY = 1'b1;
      if (i == 4) START = 1'b0;
      if (i == 8) TERM_n = 1'b0;
      tick("rdy");
    end
    TERM_n = 1'b1;
    check("rdy_wait2_clks", 9'(n_w2), 9'd4);
    check("rdy_wait1_unchanged", 9'(n_w1), 9'd2);
    tick("idle");

    // TERM and START together while BUSY: cycle ends, no restart.
    CTYPE = 3'd1; WSCNT = 3'd1; DLYSEL = 2'd1; START = 1'b1;
    tick("both_start");
    START = 1'b0;
    tick("both");
    START = 1'b1; TERM_n = 1'b0;
    tick("both_term");
    check("both_busy_after", {8'd0, BUSY}, 9'd0);
    START = 1'b0; TERM_n = 1'b1;
    tick("both_idle");
    check("both_no_restart", {8'd0, BUSY}, 9'd0);

    // Timeout: TERM never arrives.
    clear_counts();
    CTYPE = 3'd1; WSCNT = 3'd0; DLYSEL = 2'd0; START = 1'b1;
    tick("tmo_start");
    START = 1'b0;
    for (int i = 0; i < 300; i++) tick("tmo");
    check("tmo_busy_clks", 9'(n_busy), 9'd255);
    check("tmo_pulses", 9'(n_tmo), 9'd1);

    // Randomized traffic, including START/TERM collisions and resets.
    for (int i = 0; i < 3000; i++) begin
      RST    = ($urandom_range(0, 99) == 0);
      START  = ($urandom_range(0, 3) == 0);
      CTYPE  = 3'($urandom_range(0, 7));
      WSCNT  = 3'($urandom_range(0, 7));
      DLYSEL = 2'($urandom_range(0, 3));
      BUSRDY = ($urandom_range(0, 2) != 0);
      TERM_n = ($urandom_range(0, 5) != 0);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
